// File: rtl/barrett_pipe.sv
// Pipelined Barrett reducer: result = x mod m for a runtime-loaded modulus, tag carried alongside.
// Latency 4 cycles, 1/cycle throughput; out_valid_o && !out_ready_i freezes every stage and drops in_ready_o.
module barrett_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 8,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_we_i,
    input  logic [WIDTH-1:0]   cfg_m_i,
    input  logic [WIDTH+1:0]   cfg_mu_i,
    input  logic [KW-1:0]      cfg_k_i,
    output logic               cfg_err_o,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [2*WIDTH-1:0] x_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   result_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               busy_o
);
    localparam int RW = WIDTH + 2;   // residue arithmetic is mod 2^(WIDTH+2)
    localparam int QW = WIDTH + 1;   // q1 and q3 are < 2^(k+1) for legal operands
    localparam int PW = QW + RW;     // full width of q1 * mu
    localparam int SW = KW + 1;      // k+1 needs one extra bit

    logic [WIDTH-1:0] m_q;
    logic [RW-1:0]    mu_q;
    logic [KW-1:0]    k_q;
    logic             cfg_ok_q;
    logic             cfg_err_q;

    logic             s1_vld, s2_vld, s3_vld, s4_vld;
    logic [RW-1:0]    s1_x, s2_x, s3_x;
    logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag, s4_tag;
    logic [QW-1:0]    s1_q1;
    logic [PW-1:0]    s2_q2;
    logic [RW-1:0]    s3_p;
    logic [WIDTH-1:0] s4_r;

    logic             en;
    logic             accept;
    logic [SW-1:0]    sh_lo;
    logic [SW-1:0]    sh_hi;
    logic [2*WIDTH-1:0] x_shr;
    logic [PW-1:0]    q2_next;
    logic [PW-1:0]    q2_shr;
    logic [RW-1:0]    p_next;
    logic [RW-1:0]    m_ext;
    logic [RW-1:0]    r0, r1, r2;

    assign busy_o      = s1_vld | s2_vld | s3_vld | s4_vld;
    assign en          = !s4_vld || out_ready_i;
    assign in_ready_o  = en && cfg_ok_q && !cfg_we_i;
    assign accept      = in_valid_i && in_ready_o;

    assign out_valid_o = s4_vld;
    assign result_o    = s4_r;
    assign tag_o       = s4_tag;
    assign cfg_err_o   = cfg_err_q;

    // With k_q = 0 (unconfigured) sh_lo wraps to a shift past the operand width, giving 0.
    assign sh_lo   = SW'(k_q) - SW'(1);
    assign sh_hi   = SW'(k_q) + SW'(1);
    assign x_shr   = x_i >> sh_lo;
    assign q2_next = PW'(s1_q1) * PW'(mu_q);
    assign q2_shr  = s2_q2 >> sh_hi;
    assign p_next  = RW'(q2_shr[QW-1:0]) * RW'(m_q);

    assign m_ext = RW'(m_q);
    assign r0    = s3_x - s3_p;
    assign r1    = (r0 >= m_ext) ? r0 - m_ext : r0;
    assign r2    = (r1 >= m_ext) ? r1 - m_ext : r1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_q       <= '0;
            mu_q      <= '0;
            k_q       <= '0;
            cfg_ok_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            s3_vld    <= 1'b0;
            s4_vld    <= 1'b0;
            s1_x      <= '0;
            s2_x      <= '0;
            s3_x      <= '0;
            s1_tag    <= '0;
            s2_tag    <= '0;
            s3_tag    <= '0;
            s4_tag    <= '0;
            s1_q1     <= '0;
            s2_q2     <= '0;
            s3_p      <= '0;
            s4_r      <= '0;
        end else begin
            // Config may only change with an empty pipeline so in-flight operands keep their modulus.
            if (cfg_we_i) begin
                if (busy_o) begin
                    cfg_err_q <= 1'b1;
                end else begin
                    m_q      <= cfg_m_i;
                    mu_q     <= cfg_mu_i;
                    k_q      <= cfg_k_i;
                    cfg_ok_q <= 1'b1;
                end
            end
            if (en) begin
                s1_vld <= accept;
                s2_vld <= s1_vld;
                s3_vld <= s2_vld;
                s4_vld <= s3_vld;
                if (accept) begin
                    s1_x   <= x_i[RW-1:0];
                    s1_tag <= tag_i;
                    s1_q1  <= x_shr[QW-1:0];
                end
                if (s1_vld) begin
                    s2_x   <= s1_x;
                    s2_tag <= s1_tag;
                    s2_q2  <= q2_next;
                end
                if (s2_vld) begin
                    s3_x   <= s2_x;
                    s3_tag <= s2_tag;
                    s3_p   <= p_next;
                end
                if (s3_vld) begin
                    s4_tag <= s3_tag;
                    s4_r   <= r2[WIDTH-1:0];
                end
            end
        end
    end
endmodule
